servo_pwm_multi: RTL
====================

# servo_pwm_multi

Parametrised multi-channel servo PWM generator and successor to the single-servo MG995 PWM path. It drives CHANNELS independent servo outputs from one shared frame timebase. Each channel has a programmable pulse width in microseconds, clamped to the servo's legal range, with optional per-frame slew limiting toward the target. It sits between a host/control write interface and the servo pins, and exports a frame strobe and per-channel settled flags for monitor/UART logic.

## Interface
Parameters:
- CLK_HZ, 50_000_000, input clock frequency; CLK_HZ/1_000_000 (DIV) must be an integer ≥ 1.
- CHANNELS, 4, number of servo outputs, 1..16.
- PERIOD_US, 20000, frame period in µs; must be < 32768.
- MIN_US, 500, lowest legal pulse width in µs (0° on MG995).
- MAX_US, 2500, highest legal pulse width in µs (180°); must be < PERIOD_US and < 4096.
- MID_US, 1500, reset pulse width in µs (90°).
- STEP_US, 10, maximum change of the active width per frame in µs; 0 = no ramp (jump).

Ports:
- Clk_i  in  1  system clock.
- Reset_i  in  1  asynchronous, active-low reset.
- Wr_i  in  1  write strobe, one cycle per write.
- Ch_i  in  4  target channel index for the write.
- Width_i  in  12  requested pulse width in µs.
- Pwm_o  out  CHANNELS  servo pulse outputs (bit n = channel n).
- Frame_o  out  1  one-cycle pulse at the start of each frame.
- Settled_o  out  CHANNELS  bit n high when channel n's active width equals its target.
- Clamp_o  out  1  one-cycle pulse when an accepted write was clamped.
- Err_o  out  1  one-cycle pulse when a write addressed Ch_i ≥ CHANNELS.

## Operation
- Prescaler pre counts 0..DIV-1. The µs tick is asserted when pre == DIV-1.
- Frame counter fc (15 b) increments on each tick and wraps from PERIOD_US-1 to 0. The wrap event is the frame boundary.
- Per channel there are two registers: target tgt[n] and active cur[n], both 12 b.
- Write (Wr_i=1, Ch_i < CHANNELS):
  - tgt[Ch_i] ← clamp(Width_i, MIN_US, MAX_US) on the same edge.
  - Clamp_o pulses the next cycle if Width_i < MIN_US or Width_i > MAX_US.
- Write with Ch_i ≥ CHANNELS: no register changes; Err_o pulses the next cycle.
- At each frame boundary, every cur[n] is updated:
  - STEP_US = 0: cur ← tgt.
  - Otherwise: cur ← tgt if |tgt−cur| ≤ STEP_US, else cur ± STEP_US toward tgt.
- cur never changes mid-frame, so a pulse in progress is never truncated or stretched.
- Pwm_o[n] is registered: Pwm_o[n] ← (fc < cur[n]).
- Settled_o[n] is registered: Settled_o[n] ← (cur[n] == tgt[n]).
- Frame_o ← 1 in the cycle after fc becomes 0 from the wrap, aligned with the first high cycle of Pwm_o.
- All arithmetic is unsigned. The width difference is computed in 13 b so there is no wrap-around; MIN_US ≤ cur ≤ MAX_US always holds.

## Timing
- Reset (Reset_i=0, asynchronous): pre=0, fc=0, tgt[n]=cur[n]=MID_US, Pwm_o=0, Frame_o=0, Settled_o=0, Clamp_o=0, Err_o=0.
- After reset release:
  - First edge: Pwm_o goes high (all channels), Settled_o goes all-ones, and Frame_o pulses for the first frame.
  - Each high pulse lasts exactly cur[n]×DIV cycles.
  - The period is exactly PERIOD_US×DIV cycles.
- Write latency: a write lands in tgt on the strobe edge. It affects Pwm_o starting from the next frame boundary, or later if ramping.
- Write on the same edge as the frame boundary: the boundary update uses tgt as it was before that edge. The new target is applied at the following boundary.
- Back-to-back writes to the same channel: the last one wins. Every write is accepted; there is no backpressure.
- Settled_o[n] drops one cycle after a write that makes tgt ≠ cur. It rises one cycle after the boundary where cur reaches tgt.
- Reset asserted mid-frame: all outputs go low immediately. Operation restarts at frame start with MID_US widths.

## Test plan
Bench parameters: CLK_HZ=4_000_000 (DIV=4), PERIOD_US=20000.
- Reset release, no writes -> every Pwm_o high for 6000 cycles in every 80000-cycle frame; Frame_o pulses every 80000 cycles; Settled_o all-ones.
- STEP_US=0, write ch1=2500 mid-frame -> current ch1 pulse is still 6000 cycles; next frame is 10000 cycles; other channels unchanged.
- STEP_US=10, write ch0=1600 -> ch0 widths are 1510, 1520 … 1600 µs over 10 frames; Settled_o[0] low until the 10th boundary, then high.
- Write ch2=100, then ch2=3000 -> two Clamp_o pulses; tgt[2] is 500, then 2500; ch2 pulses never leave 2000..10000 cycles.
- Write Ch_i=7 with CHANNELS=4 -> Err_o pulse; all tgt unchanged; Pwm_o unaffected.
- Write coincident with a frame boundary, plus Reset_i pulsed low mid-pulse -> write applied one frame later; on reset, Pwm_o low within 0 cycles, then restart with 6000-cycle pulses.

Source files
------------

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM generator: shared µs prescaler and frame counter,
// per-channel clamped targets with optional per-frame slew toward the target.
module servo_pwm_multi #(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned PERIOD_US = 20000,
  parameter int unsigned MIN_US    = 500,
  parameter int unsigned MAX_US    = 2500,
  parameter int unsigned MID_US    = 1500,
  parameter int unsigned STEP_US   = 10
) (
  input  logic                Clk_i,
  input  logic                Reset_i,
  input  logic                Wr_i,
  input  logic [3:0]          Ch_i,
  input  logic [11:0]         Width_i,
  output logic [CHANNELS-1:0] Pwm_o,
  output logic                Frame_o,
  output logic [CHANNELS-1:0] Settled_o,
  output logic                Clamp_o,
  output logic                Err_o
);

  localparam int unsigned DIV = CLK_HZ / 1_000_000;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [14:0]   FC_LAST  = 15'(PERIOD_US - 1);
  localparam logic [11:0]   MIN_W    = 12'(MIN_US);
  localparam logic [11:0]   MAX_W    = 12'(MAX_US);
  localparam logic [11:0]   MID_W    = 12'(MID_US);
  localparam logic [11:0]   STEP_W   = 12'(STEP_US);
  localparam logic [12:0]   STEP_X   = 13'(STEP_US);

  logic [PW-1:0] pre_q, pre_d;
  logic [14:0]   fc_q, fc_d;
  logic          tick, wrap;

  logic [11:0] tgt_q [CHANNELS];
  logic [11:0] tgt_d [CHANNELS];
  logic [11:0] cur_q [CHANNELS];
  logic [11:0] cur_d [CHANNELS];

  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic [CHANNELS-1:0] settled_q, settled_d;
  logic                frame_q, frame_d;
  logic                clamp_q, clamp_d;
  logic                err_q, err_d;

  logic        ch_ok;
  logic        out_of_range;
  logic [11:0] wr_w;

  always_comb begin
    tick  = (pre_q == PRE_LAST);
    wrap  = tick && (fc_q == FC_LAST);
    pre_d = tick ? '0 : pre_q + 1'b1;
    fc_d  = fc_q;
    if (tick) begin
      fc_d = wrap ? '0 : fc_q + 15'd1;
    end
  end

  always_comb begin
    ch_ok        = ({1'b0, Ch_i} < 5'(CHANNELS));
    out_of_range = (Width_i < MIN_W) || (Width_i > MAX_W);
    if (Width_i < MIN_W) begin
      wr_w = MIN_W;
    end else if (Width_i > MAX_W) begin
      wr_w = MAX_W;
    end else begin
      wr_w = Width_i;
    end
    clamp_d = Wr_i && ch_ok && out_of_range;
    err_d   = Wr_i && !ch_ok;
    // First cycle of a frame: pre and fc both at zero, matching the first high Pwm cycle.
    frame_d = (fc_q == '0) && (pre_q == '0);
  end

  always_comb begin
    for (int unsigned n = 0; n < CHANNELS; n++) begin
      tgt_d[n] = tgt_q[n];
      if (Wr_i && ch_ok && (Ch_i == 4'(n))) begin
        tgt_d[n] = wr_w;
      end

      // Boundary update reads tgt_q, so a write on the same edge waits one frame.
      cur_d[n] = cur_q[n];
      if (wrap) begin
        if (STEP_US == 0) begin
          cur_d[n] = tgt_q[n];
        end else if (tgt_q[n] >= cur_q[n]) begin
          if (({1'b0, tgt_q[n]} - {1'b0, cur_q[n]}) <= STEP_X) begin
            cur_d[n] = tgt_q[n];
          end else begin
            cur_d[n] = cur_q[n] + STEP_W;
          end
        end else begin
          if (({1'b0, cur_q[n]} - {1'b0, tgt_q[n]}) <= STEP_X) begin
            cur_d[n] = tgt_q[n];
          end else begin
            cur_d[n] = cur_q[n] - STEP_W;
          end
        end
      end

      pwm_d[n]     = (fc_q < {3'b000, cur_q[n]});
      settled_d[n] = (cur_q[n] == tgt_q[n]);
    end
  end

  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      pre_q <= '0;
      fc_q  <= '0;
      for (int unsigned n = 0; n < CHANNELS; n++) begin
        tgt_q[n] <= MID_W;
        cur_q[n] <= MID_W;
      end
      pwm_q     <= '0;
      settled_q <= '0;
      frame_q   <= 1'b0;
      clamp_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      pre_q <= pre_d;
      fc_q  <= fc_d;
      for (int unsigned n = 0; n < CHANNELS; n++) begin
        tgt_q[n] <= tgt_d[n];
        cur_q[n] <= cur_d[n];
      end
      pwm_q     <= pwm_d;
      settled_q <= settled_d;
      frame_q   <= frame_d;
      clamp_q   <= clamp_d;
      err_q     <= err_d;
    end
  end

  assign Pwm_o     = pwm_q;
  assign Settled_o = settled_q;
  assign Frame_o   = frame_q;
  assign Clamp_o   = clamp_q;
  assign Err_o     = err_q;

endmodule
